// File: rtl/reg_bank_reader.sv
// rtl/reg_bank_reader.sv - register bank with a clocked write port and a snapshot read port using a valid/ack handshake
module reg_bank_reader #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_wr_en,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic [WIDTH-1:0]  in_wr_data,
    input  logic              in_rd_req,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic              in_rd_ack,
    output logic              out_rd_valid,
    output logic [WIDTH-1:0]  out_rd_data,
    output logic              out_rd_err,
    output logic              out_rd_busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    logic [WIDTH-1:0] regs_q [NUM_REGS];

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_err_q, rd_err_d;

    logic             wr_in_range;
    logic             rd_in_range;
    logic             bypass;
    logic             capture;
    logic [WIDTH-1:0] rd_mux;

    assign wr_in_range = ({1'b0, in_wr_addr} < NUM_REGS_EXT);
    assign rd_in_range = ({1'b0, in_rd_addr} < NUM_REGS_EXT);

    // A write landing on the same edge as the capture must be visible in the result.
    assign bypass = in_wr_en && wr_in_range && (in_wr_addr == in_rd_addr);

    // New requests are taken when idle, or when the held result is being acked.
    assign capture = in_rd_req && ((state_q == IDLE) || in_rd_ack);

    // Read mux over the implemented registers; unimplemented addresses yield zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (in_rd_addr == ADDR_W'(i)) begin
                rd_mux = regs_q[i];
            end
        end
    end

    // Next-state for the handshake FSM and the held snapshot.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        if ((state_q == RESP) && in_rd_ack && !in_rd_req) begin
            state_d = IDLE;
        end
        if (capture) begin
            state_d = RESP;
            if (!rd_in_range) begin
                rd_data_d = '0;
                rd_err_d  = 1'b1;
            end else begin
                rd_data_d = bypass ? in_wr_data : rd_mux;
                rd_err_d  = 1'b0;
            end
        end
    end

    // Register bank; out-of-range writes never match any index and are dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (in_wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (in_wr_addr == ADDR_W'(i)) begin
                    regs_q[i] <= in_wr_data;
                end
            end
        end
    end

    // FSM state and the held response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign out_rd_valid = (state_q == RESP);
    assign out_rd_data  = rd_data_q;
    assign out_rd_err   = rd_err_q;
    assign out_rd_busy  = (state_q == RESP) && !in_rd_ack;

endmodule

// File: tb/tb_reg_bank_reader.sv
// tb/tb_reg_bank_reader.sv - directed self-checking bench for reg_bank_reader
module tb_reg_bank_reader;

    logic        CLK;
    logic        RST;

    logic        wr_en, rd_req, rd_ack;
    logic [2:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        valid, err, busy;
    logic [15:0] data;

    logic        wr_en6, rd_req6, rd_ack6;
    logic [2:0]  wr_addr6, rd_addr6;
    logic [15:0] wr_data6;
    logic        valid6, err6, busy6;
    logic [15:0] data6;

    int tests_run;
    int tests_failed;

    reg_bank_reader #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .in_wr_en(wr_en), .in_wr_addr(wr_addr), .in_wr_data(wr_data),
        .in_rd_req(rd_req), .in_rd_addr(rd_addr), .in_rd_ack(rd_ack),
        .out_rd_valid(valid), .out_rd_data(data), .out_rd_err(err), .out_rd_busy(busy)
    );

    reg_bank_reader #(.WIDTH(16), .NUM_REGS(6), .ADDR_W(3)) dut6 (
        .CLK(CLK), .RST(RST),
        .in_wr_en(wr_en6), .in_wr_addr(wr_addr6), .in_wr_data(wr_data6),
        .in_rd_req(rd_req6), .in_rd_addr(rd_addr6), .in_rd_ack(rd_ack6),
        .out_rd_valid(valid6), .out_rd_data(data6), .out_rd_err(err6), .out_rd_busy(busy6)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2;
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid); end
        tests_run++;
        if (data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h expected 0000", data); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic_hold();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_valid: got %b expected 0", valid); end
        rd_req = 1'b1; rd_addr = 3'd3;
        tick();
        tests_run++;
        if (valid !== 1'b1 || data !== 16'hBEEF || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_first: got valid=%b data=%h err=%b expected valid=1 data=beef err=0", valid, data, err);
        end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b expected 1", busy); end
        // Hold ack low; a req arriving without ack must be ignored.
        for (int i = 0; i < 4; i++) begin
            rd_req = (i >= 2); rd_addr = 3'd0;
            tick();
            tests_run++;
            if (valid !== 1'b1 || data !== 16'hBEEF) begin
                tests_failed++;
                $display("FAIL basic_hold_%0d: got valid=%b data=%h expected valid=1 data=beef", i, valid, data);
            end
        end
        rd_req = 1'b0; rd_ack = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_ack: got %b expected 0", busy); end
        tick();
        rd_ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL basic_release: got %b expected 0", valid); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
        rd_req = 1'b1; rd_addr = 3'd2;
        tick();
        wr_en = 1'b0; rd_req = 1'b0;
        tests_run++;
        if (valid !== 1'b1 || data !== 16'h1234) begin
            tests_failed++;
            $display("FAIL bypass: got valid=%b data=%h expected valid=1 data=1234", valid, data);
        end
    endtask

    task automatic test_snapshot();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        tick();
        tests_run++;
        if (data !== 16'h1234) begin tests_failed++; $display("FAIL snapshot_hold: got %h expected 1234", data); end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL snapshot_release: got %b expected 0", valid); end
        rd_req = 1'b1; rd_addr = 3'd2;
        tick();
        rd_req = 1'b0;
        tests_run++;
        if (data !== 16'hFFFF) begin tests_failed++; $display("FAIL snapshot_write_landed: got %h expected ffff", data); end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
        tick();
        wr_addr = 3'd4; wr_data = 16'h4444;
        tick();
        wr_en = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd0;
        tick();
        tests_run++;
        if (valid !== 1'b1 || data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL b2b_first: got valid=%b data=%h expected valid=1 data=0000", valid, data);
        end
        rd_ack = 1'b1; rd_addr = 3'd1;
        tick();
        tests_run++;
        if (valid !== 1'b1 || data !== 16'h1111) begin
            tests_failed++;
            $display("FAIL b2b_reg1: got valid=%b data=%h expected valid=1 data=1111", valid, data);
        end
        rd_addr = 3'd4;
        tick();
        tests_run++;
        if (valid !== 1'b1 || data !== 16'h4444) begin
            tests_failed++;
            $display("FAIL b2b_reg4: got valid=%b data=%h expected valid=1 data=4444", valid, data);
        end
        rd_req = 1'b0;
        tick();
        rd_ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_release: got %b expected 0", valid); end
    endtask

    task automatic test_ack_idle();
        rd_ack = 1'b1;
        tick();
        tick();
        rd_ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_idle: got valid=%b busy=%b expected valid=0 busy=0", valid, busy);
        end
    endtask

    task automatic test_reset_mid_resp();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
        tick();
        wr_en = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd5;
        tick();
        rd_req = 1'b0;
        tests_run++;
        if (valid !== 1'b1 || data !== 16'h5555) begin
            tests_failed++;
            $display("FAIL midreset_pre: got valid=%b data=%h expected valid=1 data=5555", valid, data);
        end
        #1;
        RST = 1'b1;
        #1;
        tests_run++;
        if (valid !== 1'b0 || data !== 16'h0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: got valid=%b data=%h busy=%b expected valid=0 data=0000 busy=0", valid, data, busy);
        end
        @(negedge CLK);
        RST = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd5;
        tick();
        rd_req = 1'b0;
        tests_run++;
        if (valid !== 1'b1 || data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL midreset_reg5: got valid=%b data=%h expected valid=1 data=0000", valid, data);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic test_top_addr_in_range();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
        tick();
        wr_en = 1'b0;
        rd_req = 1'b1; rd_addr = 3'd7;
        tick();
        rd_req = 1'b0;
        tests_run++;
        if (data !== 16'h7777 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL top_addr8: got data=%h err=%b expected data=7777 err=0", data, err);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 6; i++) begin
            wr_en6 = 1'b1; wr_addr6 = 3'(i); wr_data6 = 16'hA0A0 + 16'(i);
            tick();
        end
        wr_addr6 = 3'd7; wr_data6 = 16'hDEAD;
        tick();
        wr_addr6 = 3'd6;
        tick();
        wr_en6 = 1'b0;
        rd_req6 = 1'b1; rd_addr6 = 3'd7;
        tick();
        tests_run++;
        if (valid6 !== 1'b1 || err6 !== 1'b1 || data6 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL oor_addr7: got valid=%b err=%b data=%h expected valid=1 err=1 data=0000", valid6, err6, data6);
        end
        rd_ack6 = 1'b1; rd_addr6 = 3'd6;
        tick();
        tests_run++;
        if (valid6 !== 1'b1 || err6 !== 1'b1 || data6 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL oor_addr6: got valid=%b err=%b data=%h expected valid=1 err=1 data=0000", valid6, err6, data6);
        end
        for (int i = 0; i < 6; i++) begin
            rd_addr6 = 3'(i);
            tick();
            tests_run++;
            if (data6 !== (16'hA0A0 + 16'(i)) || err6 !== 1'b0) begin
                tests_failed++;
                $display("FAIL oor_bank_%0d: got data=%h err=%b expected data=%h err=0", i, data6, err6, 16'hA0A0 + 16'(i));
            end
        end
        rd_req6 = 1'b0;
        tick();
        rd_ack6 = 1'b0;
        tests_run++;
        if (valid6 !== 1'b0) begin tests_failed++; $display("FAIL oor_release: got %b expected 0", valid6); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        RST = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; rd_ack = 1'b0;
        wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0;
        rd_req6 = 1'b0; rd_addr6 = '0; rd_ack6 = 1'b0;
        #3;
        test_reset();
        test_basic_hold();
        test_bypass();
        test_snapshot();
        test_back_to_back();
        test_ack_idle();
        test_reset_mid_resp();
        test_top_addr_in_range();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
